// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle events into fixed-width level bursts
// (HIGH_CYCLES high, then LOW_CYCLES low). Events that arrive during a burst
// are queued in a saturating pending counter and replayed back to back.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;

  // Per-edge event decode shared by the state and pending logic.
  logic low_end;   // last cycle of the LOW gap
  logic consume;   // a queued pulse starts the next burst on this edge
  logic direct;    // pulse_in itself starts the next burst on this edge
  logic incr;      // pulse_in must be queued on this edge

  // Next-state, duration counter and pending accounting.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    low_end = (state_q == S_LOW) && (cnt_q == '0);
    consume = low_end && (pend_q != '0);
    direct  = low_end && !consume && pulse_in;
    // A pulse seen in IDLE starts the burst itself and is never queued.
    incr    = pulse_in && (state_q != S_IDLE) && !direct;

    unique case (state_q)
      S_IDLE: begin
        if (pulse_in) begin
          state_d = S_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (consume || direct) begin
          // Back-to-back burst: no IDLE cycle in between.
          state_d = S_HIGH;
          cnt_d   = HIGH_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Consume and queue on the same edge cancel out. A queue request at
    // saturation with nothing consumed drops the pulse and flags it.
    if (incr && !consume) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (consume && !incr) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  // State, counter, pending and sticky overflow registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Moore outputs taken straight from registered state.
  assign out      = (state_q == S_HIGH);
  assign busy     = (state_q != S_IDLE);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios plus randomized
// traffic, compared each cycle against a burst-position reference model.
module tb_pulse_stretcher;

  logic       clk;
  logic       rst_a, pulse_a, out_a, busy_a, ovf_a;
  logic [2:0] pend_a;
  logic       rst_b, pulse_b, out_b, busy_b, ovf_b;
  logic [2:0] pend_b;

  int checks   = 0;
  int failures = 0;
  int bursts_b = 0;
  logic prev_out_b = 1'b0;

  // Default configuration.
  pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(3)) dut_a (
    .clk(clk), .rst(rst_a), .pulse_in(pulse_a),
    .out(out_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  // Long-burst configuration for saturation.
  pulse_stretcher #(.HIGH_CYCLES(8), .LOW_CYCLES(2), .PEND_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .pulse_in(pulse_b),
    .out(out_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position inside the current burst period (-1 = idle).
  typedef struct {
    int pos;
    int pend;
    bit ovf;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t m;
    m.pos  = -1;
    m.pend = 0;
    m.ovf  = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit p, input bit r,
                                 input int h, input int l, input int w);
    mdl_t n;
    int   per;
    int   pmax;
    bit   last, cons, dir;
    n    = m;
    per  = h + l;
    pmax = (1 << w) - 1;
    if (r) return mreset();
    if (m.pos < 0) begin
      if (p) n.pos = 0;
      return n;
    end
    last  = (m.pos == per - 1);
    cons  = last && (m.pend > 0);
    dir   = last && !cons && p;
    n.pos = last ? ((cons || dir) ? 0 : -1) : m.pos + 1;
    if (p && !dir && !cons) begin
      if (m.pend == pmax) n.ovf = 1'b1;
      else n.pend = m.pend + 1;
    end else if (cons && !p) begin
      n.pend = m.pend - 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string nm, input mdl_t m, input int h,
                             input logic o, input logic b,
                             input logic [2:0] pe, input logic ov);
    check({nm, "_out"},  32'(o),  32'((m.pos >= 0) && (m.pos < h)));
    check({nm, "_busy"}, 32'(b),  32'(m.pos >= 0));
    check({nm, "_pend"}, 32'(pe), 32'(m.pend));
    check({nm, "_ovf"},  32'(ov), 32'(m.ovf));
  endtask

  // One cycle: compare current outputs, drive inputs, clock, advance models.
  task automatic step(input bit pa, input bit ra, input bit pb, input bit rb);
    check_model("a", ma, 4, out_a, busy_a, pend_a, ovf_a);
    check_model("b", mb, 8, out_b, busy_b, pend_b, ovf_b);
    if (out_b && !prev_out_b) bursts_b++;
    prev_out_b = out_b;
    pulse_a = pa;
    rst_a   = ra;
    pulse_b = pb;
    rst_b   = rb;
    @(posedge clk);
    ma = mstep(ma, pa, ra, 4, 2, 3);
    mb = mstep(mb, pb, rb, 8, 2, 3);
    #1;
  endtask

  initial begin
    int thr_a, thr_b;
    rst_a = 1'b1; rst_b = 1'b1; pulse_a = 1'b0; pulse_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ma = mreset();
    mb = mreset();

    // Reset state.
    check("rst_out",  32'(out_a),  32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_pend", 32'(pend_a), 32'd0);
    check("rst_ovf",  32'(ovf_a),  32'd0);

    // Single pulse in cycle 0.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      check("s1_out",  32'(out_a),  32'(c >= 1 && c <= 4));
      check("s1_busy", 32'(busy_a), 32'(c >= 1 && c <= 6));
      check("s1_pend", 32'(pend_a), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Pulses in cycles 0, 1, 2: two queued bursts.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= 21; c++) begin
      check("s2_out", 32'(out_a),
            32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)));
      check("s2_pend", 32'(pend_a),
            32'((c <= 1) ? 0 : (c == 2) ? 1 : (c < 7) ? 2 : (c < 13) ? 1 : 0));
      check("s2_busy", 32'(busy_a), 32'(c >= 1 && c <= 18));
      step(c <= 2, 1'b0, 1'b0, 1'b0);
    end

    // Pulse on the final LOW cycle restarts with no IDLE gap.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= 14; c++) begin
      check("s3_out",  32'(out_a),  32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
      check("s3_busy", 32'(busy_a), 32'(c >= 1 && c <= 12));
      check("s3_pend", 32'(pend_a), 32'd0);
      step(c == 0 || c == 6, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-burst aborts everything.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= 14; c++) begin
      if (c >= 3) begin
        check("s5_out",  32'(out_a),  32'd0);
        check("s5_busy", 32'(busy_a), 32'd0);
        check("s5_pend", 32'(pend_a), 32'd0);
        check("s5_ovf",  32'(ovf_a),  32'd0);
      end
      step(c <= 1, c == 2, 1'b0, 1'b0);
    end

    // Pulse on the LOW-end edge with pending=3: consume and queue cancel.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= 9; c++) begin
      if (c >= 4 && c <= 7) check("s6_pend", 32'(pend_a), 32'd3);
      if (c == 7) check("s6_out", 32'(out_a), 32'd1);
      step(c <= 3 || c == 6, 1'b0, 1'b0, 1'b0);
    end

    // Saturation on the long-burst instance: held high for 10 cycles.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    bursts_b = 0;
    for (int c = 0; c <= 9; c++) begin
      if (c == 8) check("s4_pend7", 32'(pend_b), 32'd7);
      if (c == 8) check("s4_ovf_pre", 32'(ovf_b), 32'd0);
      if (c == 9) check("s4_ovf", 32'(ovf_b), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 200 && busy_b; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("s4_idle",   32'(busy_b), 32'd0);
    check("s4_bursts", 32'(bursts_b), 32'd8);
    check("s4_sticky", 32'(ovf_b), 32'd1);

    // Randomized traffic with varying density and occasional resets.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    thr_a = 20;
    thr_b = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) begin
        thr_a = int'($urandom_range(0, 100));
        thr_b = int'($urandom_range(0, 100));
      end
      step(int'($urandom_range(0, 99)) < thr_a, $urandom_range(0, 299) == 0,
           int'($urandom_range(0, 99)) < thr_b, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
